// File: rtl/riscv_hwloop_controller.sv
// Hardware-loop controller: matches fetch PC against loop end addresses, requests redirects and decrements.
// Optional macro HWLP_PERF_COUNT_EN adds hwlp_jump_cnt_o, a count of acknowledged jumps.
module riscv_hwloop_controller #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_valid_i,
  input  logic [31:0]             current_pc_i,
  input  logic                    jump_ack_i,
  input  logic                    valid_i,
  input  logic                    flush_i,
  input  logic [N_REGS-1:0][31:0] hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0] hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0] hwlp_counter_i,
  output logic                    hwlp_jump_o,
  output logic [31:0]             hwlp_targ_addr_o,
  output logic [N_REGS-1:0]       hwlp_dec_cnt_o,
  output logic                    hwlp_stall_o
`ifdef HWLP_PERF_COUNT_EN
  ,
  output logic [31:0]             hwlp_jump_cnt_o
`endif
);

  typedef enum logic {IDLE, JUMP_REQ} state_e;

  state_e                  state_q;
  logic                    jump_q;
  logic [31:0]             targ_q;
  logic [N_REGS-1:0]       pending_q;

  logic [N_REGS-1:0]       cand;
  logic [N_REGS-1:0]       win_oh;
  logic [N_REG_BITS-1:0]   win_idx;
  logic                    win_found;
  logic                    recog;

  // Lowest index wins so the innermost loop always acts first on a shared end PC.
  always_comb begin
    cand      = '0;
    win_oh    = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned k = 0; k < N_REGS; k++) begin
      cand[k] = (current_pc_i == hwlp_end_addr_i[k]) && (hwlp_counter_i[k] != '0);
      if (cand[k] && !win_found) begin
        win_found = 1'b1;
        win_idx   = N_REG_BITS'(k);
        win_oh[k] = 1'b1;
      end
    end
  end

  assign recog        = fetch_valid_i && (state_q == IDLE) && (pending_q == '0) && win_found;
  assign hwlp_stall_o = fetch_valid_i && (|cand) && ((state_q == JUMP_REQ) || (|pending_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      jump_q    <= 1'b0;
      targ_q    <= '0;
      pending_q <= '0;
    end else if (flush_i) begin
      state_q   <= IDLE;
      jump_q    <= 1'b0;
      pending_q <= '0;
    end else begin
      // The bank consumes the pending decrement on the first retiring cycle.
      if (valid_i) pending_q <= '0;
      case (state_q)
        IDLE: begin
          if (recog) begin
            pending_q <= win_oh;
            if (hwlp_counter_i[win_idx] >= 32'd2) begin
              jump_q  <= 1'b1;
              targ_q  <= hwlp_start_addr_i[win_idx];
              state_q <= JUMP_REQ;
            end
          end
        end
        JUMP_REQ: begin
          if (jump_ack_i) begin
            jump_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hwlp_jump_o      = jump_q;
  assign hwlp_targ_addr_o = targ_q;
  assign hwlp_dec_cnt_o   = pending_q;

`ifdef HWLP_PERF_COUNT_EN
  logic [31:0] jump_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_cnt_q <= '0;
    end else if (jump_q && jump_ack_i && !flush_i) begin
      jump_cnt_q <= jump_cnt_q + 32'd1;
    end
  end

  assign hwlp_jump_cnt_o = jump_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_hwloop_controller.sv
// Bench for riscv_hwloop_controller: loop-bank model plus directed loop scenarios.
module tb_riscv_hwloop_controller;

  logic              clk;
  logic              rst_n;
  logic              fetch_valid;
  logic [31:0]       pc;
  logic              ack;
  logic              valid;
  logic              flush;
  logic [1:0][31:0]  start_a;
  logic [1:0][31:0]  end_a;
  logic [1:0][31:0]  cnt;
  logic              jump;
  logic [31:0]       targ;
  logic [1:0]        dec;
  logic              stall;
`ifdef HWLP_PERF_COUNT_EN
  logic [31:0]       jump_cnt;
`endif

  logic              ld_en;
  logic [1:0][31:0]  ld_val;
  logic              chk_on;

  // Bench model: outstanding redirect, pending loop index (-1 = none), jump count
  logic              m_jump;
  logic [31:0]       m_targ;
  int                m_pend;
  logic [31:0]       m_jcnt;
  int                w;

  int                n_chk;
  int                n_fail;

  riscv_hwloop_controller #(.N_REGS(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fetch_valid_i     (fetch_valid),
    .current_pc_i      (pc),
    .jump_ack_i        (ack),
    .valid_i           (valid),
    .flush_i           (flush),
    .hwlp_start_addr_i (start_a),
    .hwlp_end_addr_i   (end_a),
    .hwlp_counter_i    (cnt),
    .hwlp_jump_o       (jump),
    .hwlp_targ_addr_o  (targ),
    .hwlp_dec_cnt_o    (dec),
    .hwlp_stall_o      (stall)
`ifdef HWLP_PERF_COUNT_EN
    ,
    .hwlp_jump_cnt_o   (jump_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Loop bank plus controller behaviour, written in terms of loop events.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_jump <= 1'b0;
      m_targ <= '0;
      m_pend <= -1;
      m_jcnt <= '0;
    end else begin
      w = -1;
      for (int k = 1; k >= 0; k--)
        if (pc == end_a[k] && cnt[k] != 0) w = k;
      if (ld_en) cnt <= ld_val;
      else if (valid && m_pend >= 0) cnt[m_pend] <= cnt[m_pend] - 32'd1;
      if (flush) begin
        m_jump <= 1'b0;
        m_pend <= -1;
      end else begin
        if (valid && m_pend >= 0) m_pend <= -1;
        if (m_jump) begin
          if (ack) begin
            m_jump <= 1'b0;
            m_jcnt <= m_jcnt + 32'd1;
          end
        end else if (fetch_valid && m_pend < 0 && w >= 0) begin
          m_pend <= w;
          if (cnt[w] >= 2) begin
            m_jump <= 1'b1;
            m_targ <= start_a[w];
          end
        end
      end
    end
  end

  function automatic logic any_cand();
    return (pc == end_a[0] && cnt[0] != 0) || (pc == end_a[1] && cnt[1] != 0);
  endfunction

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("jump_o", {31'd0, jump}, {31'd0, m_jump});
      chk("dec_cnt_o", {30'd0, dec}, (m_pend >= 0) ? (32'd1 << m_pend) : 32'd0);
      chk("stall_o", {31'd0, stall},
          {31'd0, fetch_valid && any_cand() && (m_jump || m_pend >= 0)});
      if (m_jump) chk("targ_addr_o", targ, m_targ);
`ifdef HWLP_PERF_COUNT_EN
      chk("jump_cnt_o", jump_cnt, m_jcnt);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cnt(input logic [31:0] c0, input logic [31:0] c1);
    ld_val[0] = c0;
    ld_val[1] = c1;
    ld_en = 1'b1;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    pc = a;
    fetch_valid = 1'b1;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic retire();
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic acknowledge();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; chk_on = 1'b0;
    rst_n = 1'b0; fetch_valid = 1'b0; pc = '0; ack = 1'b0; valid = 1'b0; flush = 1'b0;
    ld_en = 1'b0; ld_val = '0; cnt = '0;
    start_a[0] = 32'h100; end_a[0] = 32'h10C;
    start_a[1] = 32'h280; end_a[1] = 32'h300;
    #3;
    chk("reset jump", {31'd0, jump}, 32'd0);
    chk("reset targ", targ, 32'd0);
    chk("reset dec", {30'd0, dec}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Three-iteration loop: jump held until ack, one decrement
    set_cnt(32'd3, 32'd0);
    fetch(32'h10C);
    chk("t1 jump", {31'd0, jump}, 32'd1);
    chk("t1 targ", targ, 32'h100);
    chk("t1 dec", {30'd0, dec}, 32'd1);
    retire();
    chk("t1 dec cleared", {30'd0, dec}, 32'd0);
    tick(); tick();
    chk("t1 targ held", targ, 32'h100);
    acknowledge();
    chk("t1 jump dropped", {31'd0, jump}, 32'd0);
    chk("t1 bank cnt0", cnt[0], 32'd2);

    // Last iteration: decrement only, then PC past the end does nothing
    set_cnt(32'd1, 32'd0);
    fetch(32'h10C);
    chk("t2 no jump", {31'd0, jump}, 32'd0);
    chk("t2 dec", {30'd0, dec}, 32'd1);
    retire();
    chk("t2 bank cnt0", cnt[0], 32'd0);
    fetch(32'h110);
    chk("t2 pc110 dec", {30'd0, dec}, 32'd0);
    fetch(32'h10C);
    chk("t2 cnt0 zero dec", {30'd0, dec}, 32'd0);
    chk("t2 cnt0 zero jump", {31'd0, jump}, 32'd0);

    // Shared end address: innermost loop only
    start_a[0] = 32'h1C0; end_a[0] = 32'h200;
    start_a[1] = 32'h180; end_a[1] = 32'h200;
    set_cnt(32'd2, 32'd5);
    fetch(32'h200);
    chk("t3 targ", targ, 32'h1C0);
    chk("t3 dec", {30'd0, dec}, 32'd1);
    retire();
    acknowledge();
    chk("t3 bank cnt0", cnt[0], 32'd1);
    chk("t3 bank cnt1", cnt[1], 32'd5);

    // Back-pressure: re-presented end PC stalls, no second decrement
    start_a[0] = 32'h100; end_a[0] = 32'h10C;
    start_a[1] = 32'h280; end_a[1] = 32'h300;
    set_cnt(32'd3, 32'd0);
    fetch(32'h10C);
    fetch_valid = 1'b1;
    #1;
    chk("t4 stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      valid = (i == 1);
      tick();
    end
    valid = 1'b0;
    chk("t4 stall after dec", {31'd0, stall}, 32'd1);
    fetch_valid = 1'b0;
    acknowledge();
    chk("t4 jump dropped", {31'd0, jump}, 32'd0);
    chk("t4 bank cnt0", cnt[0], 32'd2);

    // Flush in JUMP_REQ without retirement
    fetch(32'h10C);
    chk("t5 jump", {31'd0, jump}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5 jump flushed", {31'd0, jump}, 32'd0);
    chk("t5 dec flushed", {30'd0, dec}, 32'd0);
    chk("t5 bank cnt0", cnt[0], 32'd2);
`ifdef HWLP_PERF_COUNT_EN
    chk("perf three jumps", jump_cnt, 32'd3);
`endif

    // Asynchronous reset while a jump and a decrement are outstanding
    set_cnt(32'd3, 32'd0);
    fetch(32'h10C);
    chk("t6 jump before rst", {31'd0, jump}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 rst jump", {31'd0, jump}, 32'd0);
    chk("t6 rst targ", targ, 32'd0);
    chk("t6 rst dec", {30'd0, dec}, 32'd0);
`ifdef HWLP_PERF_COUNT_EN
    chk("t6 rst perf", jump_cnt, 32'd0);
`endif
    #2;
    rst_n = 1'b1;
    tick();

    // Outer loop wins when the inner loop at the same PC has counter 0
    end_a[0] = 32'h300;
    set_cnt(32'd0, 32'd4);
    fetch(32'h300);
    chk("t7 targ", targ, 32'h280);
    chk("t7 dec", {30'd0, dec}, 32'd2);
    retire();
    acknowledge();
    chk("t7 bank cnt1", cnt[1], 32'd3);
`ifdef HWLP_PERF_COUNT_EN
    chk("t7 perf", jump_cnt, 32'd1);
`endif
    tick();

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
